// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard control unit: FSM state encoding,
// the zero-register index and the width of the stall/flush down-counter.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        BR_FLUSH   = 2'd2
    } hazard_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         REM_W    = 3;

endpackage

// File: rtl/hazard_perf_counters.sv
// Wrapping performance counters for stalled cycles and acted-upon taken branches.
// Only instantiated when HAZARD_PERF_CNT_EN is defined.
module hazard_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_inc_i,
    input  logic             flush_inc_i,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc_i) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_inc_i) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Front-end hazard control: load-use stalls and taken-branch flushes, Mealy outputs.
// Optional performance counters are enabled with the HAZARD_PERF_CNT_EN macro.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int BRANCH_PENALTY    = 1,
    parameter int CNT_W             = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IF_ID_Rs,
    input  logic [4:0]       IF_ID_Rt,
    input  logic             ID_uses_Rt,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_Rt,
    input  logic             branch_taken_EX,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             stall_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output hazard_state_e    state_dbg_o
);

    localparam logic [REM_W-1:0] LS_RELOAD = REM_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [REM_W-1:0] BR_RELOAD = REM_W'(BRANCH_PENALTY - 1);

    hazard_state_e    state_q, state_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic             hz_load;

    assign hz_load = ID_EX_MemRead && (ID_EX_Rt != REG_ZERO) &&
                     ((ID_EX_Rt == IF_ID_Rs) || (ID_uses_Rt && (ID_EX_Rt == IF_ID_Rt)));

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        flush_IF_ID = 1'b0;
        flush_ID_EX = 1'b0;
        // A taken branch overrides any stall in progress, from every state.
        if (branch_taken_EX) begin
            flush_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
            if (BRANCH_PENALTY > 1) begin
                state_d = BR_FLUSH;
                rem_d   = BR_RELOAD;
            end else begin
                state_d = RUN;
                rem_d   = '0;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (hz_load) begin
                        PCWrite     = 1'b0;
                        IF_ID_Write = 1'b0;
                        flush_ID_EX = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = LOAD_STALL;
                            rem_d   = LS_RELOAD;
                        end
                    end
                end
                LOAD_STALL: begin
                    PCWrite     = 1'b0;
                    IF_ID_Write = 1'b0;
                    flush_ID_EX = 1'b1;
                    if (rem_q == REM_W'(1)) begin
                        state_d = RUN;
                        rem_d   = '0;
                    end else begin
                        rem_d = rem_q - REM_W'(1);
                    end
                end
                BR_FLUSH: begin
                    flush_IF_ID = 1'b1;
                    flush_ID_EX = 1'b1;
                    if (rem_q == REM_W'(1)) begin
                        state_d = RUN;
                        rem_d   = '0;
                    end else begin
                        rem_d = rem_q - REM_W'(1);
                    end
                end
                default: begin
                    state_d = RUN;
                    rem_d   = '0;
                end
            endcase
        end
        if (reset) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            flush_IF_ID = 1'b0;
            flush_ID_EX = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    assign stall_busy  = (state_q != RUN);
    assign state_dbg_o = state_q;

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk        (clk),
        .rst        (reset),
        .stall_inc_i(!PCWrite && !reset),
        .flush_inc_i(branch_taken_EX && !reset),
        .stall_cnt_o(stall_cnt),
        .flush_cnt_o(flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: a default instance (1/1) and one with
// LOAD_STALL_CYCLES=3, BRANCH_PENALTY=2, both driven from the same inputs.
module tb_hazard_ctrl_unit;
  import hazard_pkg::*;

  localparam int CNT_W = 32;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic reset;
  logic [4:0] if_id_rs, if_id_rt, id_ex_rt;
  logic id_uses_rt, id_ex_memread, br;

  logic pcw0, ifw0, fif0, fex0, busy0;
  logic pcw1, ifw1, fif1, fex1, busy1;
  logic [CNT_W-1:0] sc0, fc0, sc1, fc1;
  hazard_state_e st0, st1;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.LOAD_STALL_CYCLES(1), .BRANCH_PENALTY(1), .CNT_W(CNT_W)) u_def (
    .clk(clk), .reset(reset), .IF_ID_Rs(if_id_rs), .IF_ID_Rt(if_id_rt),
    .ID_uses_Rt(id_uses_rt), .ID_EX_MemRead(id_ex_memread), .ID_EX_Rt(id_ex_rt),
    .branch_taken_EX(br), .PCWrite(pcw0), .IF_ID_Write(ifw0), .flush_IF_ID(fif0),
    .flush_ID_EX(fex0), .stall_busy(busy0), .stall_cnt(sc0), .flush_cnt(fc0),
    .state_dbg_o(st0)
  );

  hazard_ctrl_unit #(.LOAD_STALL_CYCLES(3), .BRANCH_PENALTY(2), .CNT_W(CNT_W)) u_alt (
    .clk(clk), .reset(reset), .IF_ID_Rs(if_id_rs), .IF_ID_Rt(if_id_rt),
    .ID_uses_Rt(id_uses_rt), .ID_EX_MemRead(id_ex_memread), .ID_EX_Rt(id_ex_rt),
    .branch_taken_EX(br), .PCWrite(pcw1), .IF_ID_Write(ifw1), .flush_IF_ID(fif1),
    .flush_ID_EX(fex1), .stall_busy(busy1), .stall_cnt(sc1), .flush_cnt(fc1),
    .state_dbg_o(st1)
  );

  // ---------------- reference model ----------------
  // Each instance is tracked as "bubbles still owed" and "flush cycles still owed".
  int lsc[2] = '{1, 3};
  int bpn[2] = '{1, 2};
  int stall_left[2];
  int flush_left[2];
  logic [CNT_W-1:0] m_sc[2];
  logic [CNT_W-1:0] m_fc[2];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic bit hz();
    return id_ex_memread && (id_ex_rt != 5'd0) &&
           ((id_ex_rt == if_id_rs) || (id_uses_rt && (id_ex_rt == if_id_rt)));
  endfunction

  // {PCWrite, IF_ID_Write, flush_IF_ID, flush_ID_EX, stall_busy}
  function automatic logic [4:0] model_flags(int d);
    logic busy;
    busy = !reset && (stall_left[d] > 0 || flush_left[d] > 0);
    if (reset)                           return 5'b00000;
    if (br || flush_left[d] > 0)         return {4'b1111, busy};
    if (stall_left[d] > 0 || hz())       return {4'b0001, busy};
    return {4'b1100, busy};
  endfunction

  function automatic hazard_state_e model_state(int d);
    if (reset || (flush_left[d] == 0 && stall_left[d] == 0)) return RUN;
    if (flush_left[d] > 0) return BR_FLUSH;
    return LOAD_STALL;
  endfunction

  task automatic model_update(input int d);
    if (reset) begin
      stall_left[d] = 0; flush_left[d] = 0; m_sc[d] = '0; m_fc[d] = '0;
    end else if (br) begin
      flush_left[d] = bpn[d] - 1; stall_left[d] = 0; m_fc[d] = m_fc[d] + 1'b1;
    end else if (flush_left[d] > 0) begin
      flush_left[d]--;
    end else if (stall_left[d] > 0) begin
      stall_left[d]--; m_sc[d] = m_sc[d] + 1'b1;
    end else if (hz()) begin
      stall_left[d] = lsc[d] - 1; m_sc[d] = m_sc[d] + 1'b1;
    end
  endtask

  // ---------------- scoreboard ----------------
  function automatic logic [4:0] dut_flags(int d);
    return (d == 0) ? {pcw0, ifw0, fif0, fex0, busy0} : {pcw1, ifw1, fif1, fex1, busy1};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic check_all();
    logic [CNT_W-1:0] e_sc, e_fc, a_sc, a_fc;
    hazard_state_e a_st;
    for (int d = 0; d < 2; d++) begin
      e_sc = (reset || !PERF) ? '0 : m_sc[d];
      e_fc = (reset || !PERF) ? '0 : m_fc[d];
      a_sc = (d == 0) ? sc0 : sc1;
      a_fc = (d == 0) ? fc0 : fc1;
      a_st = (d == 0) ? st0 : st1;
      chk($sformatf("dut%0d_flags", d), 64'(dut_flags(d)), 64'(model_flags(d)));
      chk($sformatf("dut%0d_state", d), 64'(a_st), 64'(model_state(d)));
      chk($sformatf("dut%0d_stall_cnt", d), 64'(a_sc), 64'(e_sc));
      chk($sformatf("dut%0d_flush_cnt", d), 64'(a_fc), 64'(e_fc));
    end
  endtask

  // One cycle: inputs already set; compare at negedge, advance the model at posedge.
  task automatic step(input string nm, input bit h_en, input int h_dut, input logic [4:0] h_exp);
    @(negedge clk);
    check_all();
    if (h_en) chk(nm, 64'(dut_flags(h_dut)), 64'(h_exp));
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                       input logic mr, input logic [4:0] ert, input logic b);
    if_id_rs = rs; if_id_rt = rt; id_uses_rt = uses;
    id_ex_memread = mr; id_ex_rt = ert; br = b;
  endtask

  task automatic idle(input int n);
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < n; i++) step("idle", 1'b0, 0, 5'b0);
  endtask

  // ---------------- vector table (default instance, always single-cycle) ----------------
  typedef struct {
    string      name;
    logic [4:0] rs, rt, ert;
    logic       uses, mr, b;
    logic [4:0] exp;
  } tvec_t;

  tvec_t tbl[9];

  function automatic tvec_t mk(string nm, logic [4:0] rs, logic [4:0] rt, logic uses,
                               logic mr, logic [4:0] ert, logic b, logic [4:0] exp);
    tvec_t v;
    v.name = nm; v.rs = rs; v.rt = rt; v.uses = uses; v.mr = mr; v.ert = ert; v.b = b; v.exp = exp;
    return v;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b1;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      stall_left[d] = 0; flush_left[d] = 0; m_sc[d] = '0; m_fc[d] = '0;
    end

    tbl[0] = mk("tbl_load_rs",   5'd5,  5'd0, 1'b0, 1'b1, 5'd5,  1'b0, 5'b00010);
    tbl[1] = mk("tbl_reg0",      5'd0,  5'd0, 1'b1, 1'b1, 5'd0,  1'b0, 5'b11000);
    tbl[2] = mk("tbl_rt_unused", 5'd1,  5'd7, 1'b0, 1'b1, 5'd7,  1'b0, 5'b11000);
    tbl[3] = mk("tbl_load_rt",   5'd1,  5'd7, 1'b1, 1'b1, 5'd7,  1'b0, 5'b00010);
    tbl[4] = mk("tbl_no_load",   5'd5,  5'd5, 1'b1, 1'b0, 5'd5,  1'b0, 5'b11000);
    tbl[5] = mk("tbl_br_hz",     5'd5,  5'd0, 1'b0, 1'b1, 5'd5,  1'b1, 5'b11110);
    tbl[6] = mk("tbl_br",        5'd2,  5'd3, 1'b1, 1'b0, 5'd9,  1'b1, 5'b11110);
    tbl[7] = mk("tbl_diff_reg",  5'd3,  5'd3, 1'b1, 1'b1, 5'd4,  1'b0, 5'b11000);
    tbl[8] = mk("tbl_r31",       5'd31, 5'd0, 1'b0, 1'b1, 5'd31, 1'b0, 5'b00010);

    // Reset state, held for two cycles
    step("reset_alt", 1'b1, 1, 5'b00000);
    step("reset_def", 1'b1, 0, 5'b00000);
    reset = 1'b0;
    idle(1);

    foreach (tbl[i]) begin
      drive(tbl[i].rs, tbl[i].rt, tbl[i].uses, tbl[i].mr, tbl[i].ert, tbl[i].b);
      step(tbl[i].name, 1'b1, 0, tbl[i].exp);
    end

    // Three-cycle load stall from a one-cycle hazard pulse
    idle(4);
    drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);
    step("ls3_c1", 1'b1, 1, 5'b00010);
    drive(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0);
    step("ls3_c2", 1'b1, 1, 5'b00011);
    step("ls3_c3", 1'b1, 1, 5'b00011);
    step("ls3_done", 1'b1, 1, 5'b11000);

    // Two-cycle branch flush
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1);
    step("br2_c1", 1'b1, 1, 5'b11110);
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0);
    step("br2_c2", 1'b1, 1, 5'b11111);
    step("br2_done", 1'b1, 1, 5'b11000);

    // Branch together with a load hazard: branch only, no stall follows
    drive(5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b1);
    step("brhz_c1", 1'b1, 1, 5'b11110);
    drive(5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0);
    step("brhz_c2", 1'b1, 1, 5'b11111);
    drive(5'd6, 5'd0, 1'b0, 1'b0, 5'd6, 1'b0);
    step("brhz_done", 1'b1, 1, 5'b11000);

    // Branch arriving mid load stall discards the stall
    drive(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0);
    step("lsbr_c1", 1'b1, 1, 5'b00010);
    drive(5'd4, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1);
    step("lsbr_c2", 1'b1, 1, 5'b11111);
    drive(5'd4, 5'd0, 1'b0, 1'b0, 5'd4, 1'b0);
    step("lsbr_c3", 1'b1, 1, 5'b11111);
    step("lsbr_done", 1'b1, 1, 5'b11000);

    // Reset during the second stall cycle
    drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0);
    step("rst_c1", 1'b1, 1, 5'b00010);
    drive(5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b0);
    reset = 1'b1;
    step("rst_mid", 1'b1, 1, 5'b00000);
    reset = 1'b0;
    step("rst_after", 1'b1, 1, 5'b11000);

    // Randomized traffic, checked against the model every cycle
    for (int n = 0; n < 400; n++) begin
      drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0));
      reset = ($urandom_range(0, 49) == 0);
      step("rand", 1'b0, 0, 5'b0);
    end
    reset = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
